// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/busy/done handshake and operand/result bus of the serial subtractor
interface serial_subtractor_if #(parameter int WIDTH = 8);
  logic start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic bin;
  logic busy;
  logic done;
  logic [WIDTH-1:0] d;
  logic bout;
  modport master(output start, a, b, bin, input busy, done, d, bout);
  modport slave(input start, a, b, bin, output busy, done, d, bout);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial D = A - B - BIN, LSB first, one full-subtractor cell and a borrow FF
module serial_subtractor #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst,
  serial_subtractor_if.slave s
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_next;
  logic [WIDTH-1:0] sa, sb, sr, sr_next;
  logic [CW-1:0] cnt;
  logic br, di, br_next, accept, last;
  assign accept = state != RUN && s.start;
  assign last = cnt == LAST;
  assign di = sa[0] ^ sb[0] ^ br;
  assign br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
  // each new difference bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts
  assign sr_next = WIDTH'({di, sr} >> 1);
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_next;
  always_comb
    state_next = state == RUN ? (last ? DONE : RUN) : (s.start ? RUN : IDLE);
  always_comb begin
    s.busy = state == RUN;
    s.done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sa <= '0;
      sb <= '0;
      sr <= '0;
      br <= 1'b0;
      cnt <= '0;
      s.d <= '0;
      s.bout <= 1'b0;
    end else if (accept) begin
      sa <= s.a;
      sb <= s.b;
      br <= s.bin;
      cnt <= '0;
    end else if (state == RUN) begin
      sa <= sa >> 1;
      sb <= sb >> 1;
      sr <= sr_next;
      br <= br_next;
      cnt <= cnt + CW'(1);
      if (last) begin
        s.d <= sr_next;
        s.bout <= br_next;
      end
    end
  end
endmodule
